// File: rtl/inst_encoder_loader.sv
`timescale 1ns/1ps
// Purpose : encodes field-level RV32I/Zicsr requests into 32-bit words and streams them,
//           with byte addresses, into instruction memory over one bounded load session.
// Latency : 1 cycle from request accept to out_valid (single output register).
// Backpres: req_ready = !out_valid | out_ready in RUN; words held stable until out_ready.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start/base_addr/count    session control, sampled only in IDLE
//   busy, done               session status (busy in RUN/DRAIN, done 1-cycle pulse)
//   req_*                    field-level request (valid/ready handshake)
//   out_*                    encoded word, its address and illegal flag (valid/ready)
//   err_sticky               any illegal request since the last accepted start
module inst_encoder_loader #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [2:0]        req_funct3,
    input  logic              req_alt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_illegal,
    output logic              err_sticky
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_ctr;
    logic [CNT_W-1:0]  remaining;

    logic [31:0] enc_inst;
    logic        enc_illegal;
    logic        accept;
    logic        consume;

    // Instruction addresses are word aligned; the low base bits are dropped.
    logic unused_base_bits;
    assign unused_base_bits = ^base_addr[1:0];

    assign req_ready = (state == S_RUN) && (!out_valid || out_ready);
    assign accept    = req_valid && req_ready;
    assign consume   = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Immediate range checks. A value fits a signed N-bit field when all
    // bits from the field's sign bit upward are identical.
    // ------------------------------------------------------------------
    logic imm_i_ok;   // [-2048, 2047]
    logic imm_b_ok;   // [-4096, 4094], even
    logic imm_j_ok;   // [-2^20, 2^20-2], even
    logic imm_sh_ok;  // 0..31

    assign imm_i_ok  = (&req_imm[31:11]) || (~|req_imm[31:11]);
    assign imm_b_ok  = ((&req_imm[31:12]) || (~|req_imm[31:12])) && !req_imm[0];
    assign imm_j_ok  = ((&req_imm[31:20]) || (~|req_imm[31:20])) && !req_imm[0];
    assign imm_sh_ok = ~|req_imm[31:5];

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic [31:0] word;
    logic        bad;

    always_comb begin
        word = NOP;
        bad  = 1'b0;
        case (req_op)
            4'd0: word = {req_imm[31:12], req_rd, 7'h37};   // LUI
            4'd1: word = {req_imm[31:12], req_rd, 7'h17};   // AUIPC
            4'd2: begin                                     // JAL
                bad  = !imm_j_ok;
                word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                        req_rd, 7'h6F};
            end
            4'd3: begin                                     // JALR
                bad  = !imm_i_ok;
                word = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'h67};
            end
            4'd4: begin                                     // BRANCH
                bad  = !imm_b_ok || (req_funct3 == 3'd2) || (req_funct3 == 3'd3);
                word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                        req_imm[4:1], req_imm[11], 7'h63};
            end
            4'd5: begin                                     // LOAD
                bad  = !imm_i_ok || (req_funct3 == 3'd3) || (req_funct3 == 3'd6)
                       || (req_funct3 == 3'd7);
                word = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'h03};
            end
            4'd6: begin                                     // STORE
                bad  = !imm_i_ok || (req_funct3 > 3'd2);
                word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], 7'h23};
            end
            4'd7: begin                                     // OPIMM
                if (req_funct3 == 3'd1 || req_funct3 == 3'd5) begin
                    // Shifts: shamt in imm[4:0], SRAI selected by alt; alt on SLLI is illegal.
                    bad  = !imm_sh_ok || (req_alt && req_funct3 == 3'd1);
                    word = {1'b0, req_alt, 5'b0, req_imm[4:0], req_rs1, req_funct3,
                            req_rd, 7'h13};
                end else begin
                    bad  = !imm_i_ok || req_alt;
                    word = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'h13};
                end
            end
            4'd8: begin                                     // OP
                bad  = req_alt && (req_funct3 != 3'd0) && (req_funct3 != 3'd5);
                word = {1'b0, req_alt, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, 7'h33};
            end
            4'd9: begin                                     // SYSTEM / CSR
                bad  = (req_funct3 == 3'd0) || (req_funct3 == 3'd4);
                word = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'h73};
            end
            default: bad = 1'b1;
        endcase
    end

    // Illegal requests still consume an address slot, but emit a NOP.
    assign enc_illegal = bad;
    assign enc_inst    = bad ? NOP : word;

    // ------------------------------------------------------------------
    // Session FSM and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_sticky  <= 1'b0;
            addr_ctr    <= '0;
            remaining   <= '0;
            out_valid   <= 1'b0;
            out_inst    <= '0;
            out_addr    <= '0;
            out_illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr_ctr   <= {base_addr[ADDR_W-1:2], 2'b00};
                        remaining  <= count;
                        err_sticky <= 1'b0;
                        if (count == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        addr_ctr  <= addr_ctr + ADDR_W'(4);
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last word leaves the output register before done is raised.
                    if (!out_valid || consume) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (accept) begin
                out_valid   <= 1'b1;
                out_inst    <= enc_inst;
                out_addr    <= addr_ctr;
                out_illegal <= enc_illegal;
                if (enc_illegal) begin
                    err_sticky <= 1'b1;
                end
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
